// File: rtl/sha256_padder_if.sv
// sha256_padder_if -- streaming word input / padded block output bundle for
// the SHA-256 message padder.
//
// Optional feature macro: SHA256_PAD_PARTIAL_WORD_EN (adds in_nbytes).
//
// Signals:
//   in_word   [31:0]   message word, big-endian (first byte in [31:24])
//   in_valid           in_word valid this cycle
//   in_last            in_word is the final word of the message
//   in_nbytes [1:0]    valid bytes in the last word, 0 means 4 (macro only)
//   in_ready           padder accepts in_word this cycle
//   out_chunk [511:0]  padded block, word 0 in [511:480]
//   out_valid          out_chunk holds a complete block
//   out_final          out_chunk is the last block (carries the length)
//   out_ready          downstream consumes out_chunk
//
// Modports: master = message source / block sink, slave = padder.
interface sha256_padder_if;
    logic [31:0]  in_word;
    logic         in_valid;
    logic         in_last;
`ifdef SHA256_PAD_PARTIAL_WORD_EN
    logic [1:0]   in_nbytes;
`endif
    logic         in_ready;
    logic [511:0] out_chunk;
    logic         out_valid;
    logic         out_final;
    logic         out_ready;

    modport master (
        output in_word, in_valid, in_last,
`ifdef SHA256_PAD_PARTIAL_WORD_EN
        output in_nbytes,
`endif
        output out_ready,
        input  in_ready, out_chunk, out_valid, out_final
    );

    modport slave (
        input  in_word, in_valid, in_last,
`ifdef SHA256_PAD_PARTIAL_WORD_EN
        input  in_nbytes,
`endif
        input  out_ready,
        output in_ready, out_chunk, out_valid, out_final
    );
endinterface

// File: rtl/sha256_padder.sv
// sha256_padder -- collects 32-bit message words into 512-bit blocks and
// applies SHA-256 padding (0x80 byte, zero fill, 64-bit bit length).
//
// Optional feature macro: SHA256_PAD_PARTIAL_WORD_EN. When defined, the last
// word may carry 1..3 valid bytes (in_nbytes); otherwise every word is 4 bytes.
//
// Parameters:
//   LEN_WIDTH  width of the message bit-length counter (zero-extended to 64)
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-high reset
//   bus        sha256_padder_if.slave (word input, block output handshakes)
module sha256_padder #(
    parameter int unsigned LEN_WIDTH = 64
) (
    input  logic           clock,
    input  logic           reset,
    sha256_padder_if.slave bus
);

    typedef enum logic [1:0] {FILL, PAD, EMIT} state_t;

    state_t               r_state;
    logic [3:0]           r_widx;
    logic [LEN_WIDTH-1:0] r_len;
    logic                 r_need80;      // 0x80 marker still to be written
    logic                 r_pad_pending; // another pure-padding block follows
    logic                 r_len_hi;      // index 14 of this block holds length[63:32]
    logic                 r_out_valid;
    logic                 r_out_final;
    logic [31:0]          r_buf [16];

    logic [31:0]          w_word;
    logic                 w_full;
    logic [LEN_WIDTH-1:0] w_len_inc;
    logic [63:0]          w_len64;

    assign w_len64 = 64'(r_len);

    // Incoming word after partial-word formatting.
    always_comb begin
        w_word    = bus.in_word;
        w_full    = 1'b1;
        w_len_inc = LEN_WIDTH'(32);
`ifdef SHA256_PAD_PARTIAL_WORD_EN
        if (bus.in_last) begin
            case (bus.in_nbytes)
                2'd1: begin
                    w_word    = {bus.in_word[31:24], 8'h80, 16'h0000};
                    w_full    = 1'b0;
                    w_len_inc = LEN_WIDTH'(8);
                end
                2'd2: begin
                    w_word    = {bus.in_word[31:16], 8'h80, 8'h00};
                    w_full    = 1'b0;
                    w_len_inc = LEN_WIDTH'(16);
                end
                2'd3: begin
                    w_word    = {bus.in_word[31:8], 8'h80};
                    w_full    = 1'b0;
                    w_len_inc = LEN_WIDTH'(24);
                end
                default: ;
            endcase
        end
`endif
    end

    assign bus.in_ready  = (r_state == FILL) && !reset;
    assign bus.out_valid = r_out_valid;
    assign bus.out_final = r_out_final;

    always_comb begin
        bus.out_chunk = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            bus.out_chunk[32*(15-i) +: 32] = r_buf[i];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= FILL;
            r_widx        <= '0;
            r_len         <= '0;
            r_need80      <= 1'b0;
            r_pad_pending <= 1'b0;
            r_len_hi      <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_final   <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            case (r_state)
                FILL: begin
                    if (bus.in_valid) begin
                        r_buf[r_widx] <= w_word;
                        r_widx        <= r_widx + 4'd1;
                        r_len         <= r_len + w_len_inc;
                        r_len_hi      <= 1'b0;
                        if (bus.in_last) begin
                            r_need80 <= w_full;
                            if (r_widx == 4'd15) begin
                                r_state       <= EMIT;
                                r_out_valid   <= 1'b1;
                                r_out_final   <= 1'b0;
                                r_pad_pending <= 1'b1;
                            end else begin
                                r_state <= PAD;
                            end
                        end else if (r_widx == 4'd15) begin
                            r_state       <= EMIT;
                            r_out_valid   <= 1'b1;
                            r_out_final   <= 1'b0;
                            r_pad_pending <= 1'b0;
                        end
                    end
                end

                PAD: begin
                    r_widx <= r_widx + 4'd1;
                    // Length goes in only if the marker is already down by
                    // index 14; otherwise the block closes with zeros and a
                    // further padding-only block carries the length.
                    if (r_widx == 4'd14 && !r_need80) begin
                        r_buf[14] <= w_len64[63:32];
                        r_len_hi  <= 1'b1;
                    end else if (r_widx == 4'd15 && r_len_hi) begin
                        r_buf[15]     <= w_len64[31:0];
                        r_len_hi      <= 1'b0;
                        r_state       <= EMIT;
                        r_out_valid   <= 1'b1;
                        r_out_final   <= 1'b1;
                        r_pad_pending <= 1'b0;
                    end else begin
                        r_buf[r_widx] <= r_need80 ? 32'h8000_0000 : 32'h0000_0000;
                        r_need80      <= 1'b0;
                        if (r_widx == 4'd15) begin
                            r_state       <= EMIT;
                            r_out_valid   <= 1'b1;
                            r_out_final   <= 1'b0;
                            r_pad_pending <= 1'b1;
                        end
                    end
                end

                EMIT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_widx      <= '0;
                        if (r_out_final) begin
                            r_len       <= '0;
                            r_need80    <= 1'b0;
                            r_out_final <= 1'b0;
                        end
                        if (r_pad_pending) begin
                            r_state       <= PAD;
                            r_pad_pending <= 1'b0;
                        end else begin
                            r_state <= FILL;
                        end
                    end
                end

                default: r_state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder -- directed bench for sha256_padder. Expected blocks are
// built by a reference padding model when a message is driven, queued, and
// compared as the padder hands blocks off.
module tb_sha256_padder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sha256_padder_if ifc ();

    sha256_padder #(.LEN_WIDTH(64)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (ifc.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [511:0] exp_chunk [$];
    logic         exp_final [$];
    logic [31:0]  msg [64];

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] want);
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic timeout_fail(input string tag);
        n_vec++;
        n_err++;
        $error("FAIL %s: timed out", tag);
    endtask

    // Reference padding: data words, marker, zeros to word 14 mod 16, length.
    task automatic model(input int n, input int nb);
        logic [31:0]  pw [$];
        logic [31:0]  w;
        logic [63:0]  len;
        logic [511:0] c;
        int           nblk;
        for (int i = 0; i < n; i++) begin
            w = msg[i];
            if (i == n - 1) begin
                case (nb)
                    1: w = {msg[i][31:24], 8'h80, 16'h0000};
                    2: w = {msg[i][31:16], 8'h80, 8'h00};
                    3: w = {msg[i][31:8], 8'h80};
                    default: ;
                endcase
            end
            pw.push_back(w);
        end
        if (nb == 0) pw.push_back(32'h8000_0000);
        while ((pw.size() % 16) != 14) pw.push_back(32'h0);
        len = 64'(n - 1) * 64'd32 + ((nb == 0) ? 64'd32 : 64'(8 * nb));
        pw.push_back(len[63:32]);
        pw.push_back(len[31:0]);
        nblk = pw.size() / 16;
        for (int b = 0; b < nblk; b++) begin
            c = '0;
            for (int k = 0; k < 16; k++) c[32*(15-k) +: 32] = pw[16*b + k];
            exp_chunk.push_back(c);
            exp_final.push_back(b == nblk - 1);
        end
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) msg[i] = $urandom;
    endtask

    // Drives msg[0..n-1]; called and returns just after a rising edge.
    task automatic send_msg(input int n, input int nb, input bit push);
        int budget;
        bit acc;
        if (push) model(n, nb);
        for (int i = 0; i < n; i++) begin
            ifc.in_valid = 1'b1;
            ifc.in_word  = msg[i];
            ifc.in_last  = (i == n - 1);
`ifdef SHA256_PAD_PARTIAL_WORD_EN
            ifc.in_nbytes = (i == n - 1) ? 2'(nb) : 2'd0;
`endif
            acc = 1'b0;
            budget = 0;
            while (!acc && budget < 200) begin
                @(negedge clk);
                acc = ifc.in_ready;
                @(posedge clk);
                #1;
                budget++;
            end
            if (!acc) timeout_fail("send_accept");
        end
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
`ifdef SHA256_PAD_PARTIAL_WORD_EN
        ifc.in_nbytes = 2'd0;
`endif
    endtask

    task automatic drain();
        int budget = 0;
        while (exp_chunk.size() != 0 && budget < 200) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (exp_chunk.size() != 0) timeout_fail("drain");
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every accepted block is checked against the queue head.
    always @(negedge clk) begin
        if (!rst && ifc.out_valid && ifc.out_ready) begin
            if (exp_chunk.size() == 0) begin
                timeout_fail("unexpected_block");
            end else begin
                chk("block_chunk", ifc.out_chunk, exp_chunk.pop_front());
                chk("block_final", 512'(ifc.out_final), 512'(exp_final.pop_front()));
            end
        end
    end

    initial begin
        int  lat;
        bit  seen;
        ifc.in_valid  = 1'b0;
        ifc.in_last   = 1'b0;
        ifc.in_word   = '0;
        ifc.out_ready = 1'b1;
`ifdef SHA256_PAD_PARTIAL_WORD_EN
        ifc.in_nbytes = 2'd0;
`endif

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready",  512'(ifc.in_ready),  512'(0));
        chk("rst_out_valid", 512'(ifc.out_valid), 512'(0));
        chk("rst_out_final", 512'(ifc.out_final), 512'(0));
        chk("rst_out_chunk", ifc.out_chunk, 512'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 512'(ifc.in_ready), 512'(1));
        @(posedge clk);
        #1;

        // Single word "abcd", with last-word-to-valid latency
        msg[0] = 32'h6162_6364;
        send_msg(1, 0, 1'b1);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            seen = ifc.out_valid;
        end
        chk("latency_1word", 512'(lat), 512'(15));
        drain();

`ifdef SHA256_PAD_PARTIAL_WORD_EN
        // "abc" as a 3-byte partial word
        msg[0] = 32'h6162_6300;
        send_msg(1, 3, 1'b1);
        drain();
        // Partial word landing at index 15
        fill_rand(16);
        send_msg(16, 1, 1'b1);
        drain();
`endif

        // Marker lands at index 14, length spills to a second block
        fill_rand(14);
        send_msg(14, 0, 1'b1);
        drain();

        // Marker lands at index 15
        fill_rand(15);
        send_msg(15, 0, 1'b1);
        drain();

        // Exactly one full block of data
        fill_rand(16);
        send_msg(16, 0, 1'b1);
        drain();

        // Two-block message, length fits in the second
        fill_rand(20);
        send_msg(20, 0, 1'b1);
        drain();

        // Downstream stall: block held, input ignored
        ifc.out_ready = 1'b0;
        fill_rand(3);
        send_msg(3, 0, 1'b1);
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            seen = ifc.out_valid;
            if (!seen) begin
                @(posedge clk);
                #1;
            end
            lat++;
        end
        if (!seen) timeout_fail("stall_wait_valid");
        for (int k = 0; k < 5; k++) begin
            chk("stall_chunk",    ifc.out_chunk, exp_chunk[0]);
            chk("stall_in_ready", 512'(ifc.in_ready), 512'(0));
            @(posedge clk);
            #1;
            ifc.in_valid = 1'b1;
            ifc.in_last  = 1'b1;
            ifc.in_word  = 32'hDEAD_BEEF;
            @(negedge clk);
        end
        ifc.in_valid  = 1'b0;
        ifc.in_last   = 1'b0;
        ifc.out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post_hs_in_ready",  512'(ifc.in_ready),  512'(1));
        chk("post_hs_out_valid", 512'(ifc.out_valid), 512'(0));
        chk("post_hs_queue",     512'(exp_chunk.size()), 512'(0));
        @(posedge clk);
        #1;

        // Reset during PAD discards the message
        fill_rand(2);
        send_msg(2, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midpad_out_valid", 512'(ifc.out_valid), 512'(0));
        chk("midpad_in_ready",  512'(ifc.in_ready),  512'(0));
        @(negedge clk);
        chk("midpad_out_chunk", ifc.out_chunk, 512'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        msg[0] = 32'h0123_4567;
        send_msg(1, 0, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
